gpu_host_sequencer: RTL
=======================

// Module: gpu_host_sequencer
// PURPOSE
//  Bus initiator that drives the GPU top's CPU register/shader bus (we/addr/wdata, rdata).
//  Accepts a command stream and turns it into bus cycles: register writes, auto-indexed
//  shader-word loads, pipeline start, register reads and status polling until idle.
//  Read and wait results return on a response channel. Sits between the host/testbench
//  command source and gpu_top.
// PARAMETERS
//  ADDR_WIDTH     32     bus address width
//  DATA_WIDTH     32     bus data width
//  INSTR_DEPTH    256    shader memory words; the shader index wraps modulo this value
//  SETTLE_CYCLES  2      idle cycles after a START write before status is first sampled
//  POLL_TIMEOUT   65535  maximum number of status samples taken by OP_WAIT
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous reset, active-high
//  i_cmd_valid  in   1           command valid
//  o_cmd_ready  out  1           command accepted when valid&ready
//  i_cmd_op     in   3           gpu_host_pkg::host_op_t
//  i_cmd_addr   in   ADDR_WIDTH  byte address (OP_WRITE/OP_READ only)
//  i_cmd_data   in   DATA_WIDTH  write data / shader word / start index
//  o_bus_we     out  1           bus write strobe, one cycle per write
//  o_bus_addr   out  ADDR_WIDTH  bus address (registered)
//  o_bus_wdata  out  DATA_WIDTH  bus write data (registered)
//  i_bus_rdata  in   DATA_WIDTH  combinational read data for o_bus_addr
//  o_rsp_valid  out  1           response valid, held until accepted
//  i_rsp_ready  in   1           response accepted when valid&ready
//  o_rsp_data   out  DATA_WIDTH  read data (OP_READ) or status samples taken (OP_WAIT)
//  o_rsp_err    out  1           OP_WAIT timed out
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-high.
//  Reset: state S_IDLE; o_bus_we=0, o_bus_addr=0, o_bus_wdata=0, o_rsp_valid=0,
//    o_rsp_data=0, o_rsp_err=0, shader index=0, counters=0. A reset mid-command aborts
//    it. A pending response is dropped. Any strobe in flight is deasserted on that edge.
//  o_cmd_ready = (state==S_IDLE). The block accepts one command at a time.
//  Each command is accepted in S_IDLE. The op selects the action:
//   OP_WRITE: next cycle o_bus_we=1, addr/wdata=cmd. Back to S_IDLE. No response.
//   OP_SHADER: writes to ADDR_SHADER_BASE + 4*idx. Then idx=(idx+1)%INSTR_DEPTH.
//     Write 255 is followed by index 0. No response.
//   OP_SHADER_IDX: idx = cmd_data modulo INSTR_DEPTH. No bus cycle, no response.
//   OP_START: writes 32'h1 to ADDR_CONTROL. Then S_SETTLE for SETTLE_CYCLES cycles
//     with we=0, then S_IDLE. No response.
//   OP_READ: S_READ drives o_bus_addr=cmd_addr with we=0 for 1 cycle. It captures
//     i_bus_rdata at the end of that cycle. Then S_RESP with rsp_data=captured, err=0.
//   OP_WAIT: S_POLL drives ADDR_STATUS with we=0. It samples bit0 (busy) every cycle
//     and counts the samples.
//     - busy==0: S_RESP with data=count (a first-sample idle gives 1), err=0.
//     - count reaches POLL_TIMEOUT while still busy: S_RESP with data=POLL_TIMEOUT, err=1.
//   Undefined op: consumed as a no-op; one S_RESP with err=1, data=0.
//  S_RESP: o_rsp_valid=1 with data/err stable. It leaves on valid&ready and returns to
//    S_IDLE the next cycle.
//  Timing: every write state lasts exactly 1 cycle. Back-to-back writes give a
//    command-to-command throughput of 1 per 2 cycles (accept cycle, bus cycle).
//  Address/data registers hold their last values while idle. Only o_bus_we pulses.
//  Width rules:
//   - shader address is computed at ADDR_WIDTH and the index is zero-extended;
//   - the poll counter is $clog2(POLL_TIMEOUT+1) bits and zero-extended into rsp_data.
// STRUCTURE
//  gpu_host_pkg holds:
//   - host_op_t enum: OP_WRITE=0, OP_SHADER=1, OP_SHADER_IDX=2, OP_START=3, OP_READ=4,
//     OP_WAIT=5;
//   - state enum;
//   - ADDR_CONTROL=0x0, ADDR_STATUS=0x4, ADDR_VERTEX_BASE=0x8, ADDR_VERTEX_COUNT=0xC,
//     ADDR_PC=0x10, ADDR_SHADER_BASE=0x1000; gpu_top later migrates to these.
//  Single flat module: one FSM, shader index counter, poll/settle counter. No sub-modules.
// TESTING
//  1. Reset: rst=1 for 3 cycles -> all bus and rsp outputs 0, o_cmd_ready=1 after the
//     first edge.
//  2. OP_SHADER_IDX 254, then 3x OP_SHADER 0xA,0xB,0xC -> writes at 0x13F8, 0x13FC,
//     0x1000 with those data.
//  3. OP_WRITE 0x8 data 0x4000 then OP_READ 0x8 (bus model echoes) -> one we pulse,
//     then rsp_data=0x4000, err=0.
//  4. OP_START, then OP_WAIT with a model busy for 10 cycles after the write ->
//     ADDR_CONTROL=1 write, 2 settle cycles, rsp err=0 with data equal to the samples taken.
//  5. OP_WAIT with busy stuck at 1, POLL_TIMEOUT=16 -> rsp after 16 samples:
//     data=16, err=1.
//  6. Reset during S_POLL, and reset while S_RESP is stalled with i_rsp_ready=0 ->
//     rsp_valid=0 and o_cmd_ready=1 after the edge; shader index returns to 0.

Source files
------------

// File: rtl/gpu_host_pkg.sv
// rtl/gpu_host_pkg.sv - host sequencer command ops, FSM states and GPU register map
package gpu_host_pkg;

  typedef enum logic [2:0] {
    OP_WRITE      = 3'd0,
    OP_SHADER     = 3'd1,
    OP_SHADER_IDX = 3'd2,
    OP_START      = 3'd3,
    OP_READ       = 3'd4,
    OP_WAIT       = 3'd5
  } host_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_START,
    S_SETTLE,
    S_READ,
    S_POLL,
    S_RESP
  } state_t;

  localparam logic [31:0] ADDR_CONTROL      = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS       = 32'h0000_0004;
  localparam logic [31:0] ADDR_VERTEX_BASE  = 32'h0000_0008;
  localparam logic [31:0] ADDR_VERTEX_COUNT = 32'h0000_000C;
  localparam logic [31:0] ADDR_PC           = 32'h0000_0010;
  localparam logic [31:0] ADDR_SHADER_BASE  = 32'h0000_1000;

endpackage

// File: rtl/gpu_host_sequencer.sv
// rtl/gpu_host_sequencer.sv - command stream to GPU register/shader bus initiator
module gpu_host_sequencer
  import gpu_host_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int INSTR_DEPTH   = 256,
  parameter int SETTLE_CYCLES = 2,
  parameter int POLL_TIMEOUT  = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [2:0]            i_cmd_op,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_bus_we,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err
);

  localparam int IDX_W   = (INSTR_DEPTH > 1) ? $clog2(INSTR_DEPTH) : 1;
  // One counter serves both settle and poll, so size it for the larger of the two.
  localparam int CNT_MAX = (POLL_TIMEOUT > SETTLE_CYCLES) ? POLL_TIMEOUT : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  state_t                state_q, state_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  host_op_t              cmd_op;
  logic [CNT_W-1:0]      cnt_inc;
  logic [IDX_W-1:0]      idx_next;
  logic [ADDR_WIDTH-1:0] shader_addr;

  assign cmd_op      = host_op_t'(i_cmd_op);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign idx_next    = (idx_q == IDX_W'(INSTR_DEPTH - 1)) ? '0 : idx_q + IDX_W'(1);
  assign shader_addr = ADDR_WIDTH'(ADDR_SHADER_BASE) + (ADDR_WIDTH'(idx_q) << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_we_d    = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          case (cmd_op)
            OP_WRITE: begin
              bus_we_d    = 1'b1;
              bus_addr_d  = i_cmd_addr;
              bus_wdata_d = i_cmd_data;
              state_d     = S_WRITE;
            end
            OP_SHADER: begin
              bus_we_d    = 1'b1;
              bus_addr_d  = shader_addr;
              bus_wdata_d = i_cmd_data;
              idx_d       = idx_next;
              state_d     = S_WRITE;
            end
            OP_SHADER_IDX: begin
              idx_d = IDX_W'(i_cmd_data % DATA_WIDTH'(INSTR_DEPTH));
            end
            OP_START: begin
              bus_we_d    = 1'b1;
              bus_addr_d  = ADDR_WIDTH'(ADDR_CONTROL);
              bus_wdata_d = DATA_WIDTH'(1);
              state_d     = S_START;
            end
            OP_READ: begin
              bus_addr_d = i_cmd_addr;
              state_d    = S_READ;
            end
            OP_WAIT: begin
              bus_addr_d = ADDR_WIDTH'(ADDR_STATUS);
              cnt_d      = '0;
              state_d    = S_POLL;
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_err_d   = 1'b1;
              state_d     = S_RESP;
            end
          endcase
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_START: begin
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES == 0) ? S_IDLE : S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_W'(SETTLE_CYCLES)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = i_bus_rdata;
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
      end
      S_POLL: begin
        cnt_d = cnt_inc;
        // cnt_inc is the number of status samples taken including this one.
        if (!i_bus_rdata[0]) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = DATA_WIDTH'(cnt_inc);
          rsp_err_d   = 1'b0;
          cnt_d       = '0;
          state_d     = S_RESP;
        end else if (cnt_inc == CNT_W'(POLL_TIMEOUT)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = DATA_WIDTH'(POLL_TIMEOUT);
          rsp_err_d   = 1'b1;
          cnt_d       = '0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_bus_we    = bus_we_q;
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_wdata = bus_wdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule
